// File: rtl/rr_arb_mux.sv
// Round-robin / fixed-priority N-channel arbiter feeding a one-entry output register.
// The arbiter is combinational; the selected word is captured on the handshake edge.
module rr_arb_mux #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4,
  parameter int MODE   = 0,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic                out_valid_r;
  logic [WIDTH-1:0]    out_data_r;
  logic [SEL_W-1:0]    out_sel_r;
  logic [SEL_W-1:0]    rr_ptr_r;
  logic                load_s;
  logic                gnt_any_s;
  logic [SEL_W-1:0]    gnt_idx_s;
  logic [NUM_CH-1:0]   grant_s;
  logic [SEL_W-1:0]    ptr_next_s;

  // Scan requesters starting at ptr (MODE 0) or at 0 (MODE 1); returns {found, index}.
  // The scan never goes past NUM_CH-1, so out-of-range indices are never granted.
  function automatic logic [SEL_W:0] pick_req(input logic [NUM_CH-1:0] req,
                                              input logic [SEL_W-1:0]  ptr);
    logic             found;
    logic [SEL_W-1:0] sel;
    int               idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (MODE == 1) begin
        idx = k;
      end else begin
        idx = (int'(ptr) + k) % NUM_CH;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx[SEL_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  // Combinational grant, load enable and next round-robin pointer.
  always_comb begin
    load_s                 = ~out_valid_r | out_ready;
    {gnt_any_s, gnt_idx_s} = pick_req(in_valid, rr_ptr_r);
    if (gnt_any_s) begin
      grant_s = NUM_CH'(1) << gnt_idx_s;
    end else begin
      grant_s = '0;
    end
    if (gnt_idx_s == SEL_W'(NUM_CH - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gnt_idx_s + SEL_W'(1);
    end
  end

  // in_ready is forced low while reset is held, even though load is high then.
  assign in_ready  = grant_s & {NUM_CH{load_s & rst_n}};
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

  // Output register and round-robin pointer; pointer moves only on an accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      rr_ptr_r    <= '0;
    end else if (load_s) begin
      if (gnt_any_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= in_data[gnt_idx_s*WIDTH +: WIDTH];
        out_sel_r   <= gnt_idx_s;
        if (MODE == 0) begin
          rr_ptr_r <= ptr_next_s;
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else begin
        out_valid_r <= 1'b0;
        out_data_r  <= out_data_r;
        out_sel_r   <= out_sel_r;
        rr_ptr_r    <= rr_ptr_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_sel_r   <= out_sel_r;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a round-robin and a fixed-priority instance share stimulus;
// directed table, hand sequences for backpressure/reset, then random traffic vs a model.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic [3:0]  in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [3:0]  out_data0, out_data1;
  logic [1:0]  out_sel0, out_sel1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // model state: output register per mode and the round-robin pointer
  logic       mv [2];
  logic [3:0] md [2];
  int         ms [2];
  int         mptr;
  logic [3:0] snap_rdy0, snap_rdy1;

  rr_arb_mux #(.WIDTH(4), .NUM_CH(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
    .out_sel(out_sel0), .out_ready(out_ready));

  rr_arb_mux #(.WIDTH(4), .NUM_CH(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_sel(out_sel1), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // winner by distance from the pointer (mode 0) or by plain index (mode 1); -1 if none
  function automatic int pick(input int m, input logic [3:0] v, input int ptr);
    int best, bestd, d;
    best = -1; bestd = 99;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        d = (m == 0) ? (i - ptr + 4) % 4 : i;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] exp_ready(input int m);
    int b;
    b = pick(m, in_valid, mptr);
    if ((!mv[m] || out_ready) && b >= 0) return 4'(1 << b);
    return 4'h0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin mv[m] = 1'b0; md[m] = 4'h0; ms[m] = 0; end
    mptr = 0;
  endtask

  task automatic model_clock();
    int b [2];
    logic ld [2];
    for (int m = 0; m < 2; m++) begin
      b[m]  = pick(m, in_valid, mptr);
      ld[m] = !mv[m] || out_ready;
    end
    for (int m = 0; m < 2; m++) begin
      if (ld[m]) begin
        if (b[m] >= 0) begin
          mv[m] = 1'b1; md[m] = in_data[b[m]*4 +: 4]; ms[m] = b[m];
          if (m == 0) mptr = (b[m] + 1) % 4;
        end else begin
          mv[m] = 1'b0;
        end
      end
    end
  endtask

  // one clock: drive, check in_ready before the edge, check outputs after it
  task automatic step(input logic [3:0] v, input logic rdy);
    in_valid = v; out_ready = rdy;
    #1;
    snap_rdy0 = in_ready0; snap_rdy1 = in_ready1;
    chk("rr in_ready", in_ready0, exp_ready(0));
    chk("fp in_ready", in_ready1, exp_ready(1));
    @(posedge clk);
    model_clock();
    #1;
    chk("rr out_valid", out_valid0, mv[0]);
    chk("rr out_data", out_data0, md[0]);
    chk("rr out_sel", out_sel0, 32'(ms[0]));
    chk("fp out_valid", out_valid1, mv[1]);
    chk("fp out_data", out_data1, md[1]);
    chk("fp out_sel", out_sel1, 32'(ms[1]));
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] er0; logic ev; logic [1:0] es0; logic [3:0] ed0;
    logic [3:0] er1; logic [1:0] es1;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // all valid round-robin, ch3-only wrap, ch0+ch3, ch2, idle, resume, ch0 dropped
    tbl[0]  = '{4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 4'h1, 2'd0};
    tbl[1]  = '{4'hF, 4'h2, 1'b1, 2'd1, 4'h4, 4'h1, 2'd0};
    tbl[2]  = '{4'hF, 4'h4, 1'b1, 2'd2, 4'hA, 4'h1, 2'd0};
    tbl[3]  = '{4'hF, 4'h8, 1'b1, 2'd3, 4'h7, 4'h1, 2'd0};
    tbl[4]  = '{4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 4'h1, 2'd0};
    tbl[5]  = '{4'hF, 4'h2, 1'b1, 2'd1, 4'h4, 4'h1, 2'd0};
    tbl[6]  = '{4'hF, 4'h4, 1'b1, 2'd2, 4'hA, 4'h1, 2'd0};
    tbl[7]  = '{4'hF, 4'h8, 1'b1, 2'd3, 4'h7, 4'h1, 2'd0};
    tbl[8]  = '{4'h8, 4'h8, 1'b1, 2'd3, 4'h7, 4'h8, 2'd3};
    tbl[9]  = '{4'h8, 4'h8, 1'b1, 2'd3, 4'h7, 4'h8, 2'd3};
    tbl[10] = '{4'h9, 4'h1, 1'b1, 2'd0, 4'h0, 4'h1, 2'd0};
    tbl[11] = '{4'h4, 4'h4, 1'b1, 2'd2, 4'hA, 4'h4, 2'd2};
    tbl[12] = '{4'h0, 4'h0, 1'b0, 2'd2, 4'hA, 4'h0, 2'd2};
    tbl[13] = '{4'hF, 4'h8, 1'b1, 2'd3, 4'h7, 4'h1, 2'd0};
    tbl[14] = '{4'hE, 4'h2, 1'b1, 2'd1, 4'h4, 4'h2, 2'd1};
    tbl[15] = '{4'hF, 4'h4, 1'b1, 2'd2, 4'hA, 4'h1, 2'd0};

    rst_n = 1'b0; in_valid = 4'h0; out_ready = 1'b0;
    in_data = {4'h7, 4'hA, 4'h4, 4'h0};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid0, 1'b0);
    chk("reset out_sel", out_sel0, 2'd0);
    chk("reset in_ready", {in_ready1, in_ready0}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, 1'b1);
      chk("tbl rr in_ready", snap_rdy0, tbl[i].er0);
      chk("tbl rr out_valid", out_valid0, tbl[i].ev);
      chk("tbl rr out_sel", out_sel0, tbl[i].es0);
      chk("tbl rr out_data", out_data0, tbl[i].ed0);
      chk("tbl fp in_ready", snap_rdy1, tbl[i].er1);
      chk("tbl fp out_valid", out_valid1, tbl[i].ev);
      chk("tbl fp out_sel", out_sel1, tbl[i].es1);
    end

    // backpressure: rr holds ch2 word A with the pointer at 3
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b0);
      chk("bp in_ready", {snap_rdy1, snap_rdy0}, 8'h00);
      chk("bp hold data", out_data0, 4'hA);
      chk("bp hold valid", out_valid0, 1'b1);
    end
    step(4'hF, 1'b1);
    chk("bp release grant", snap_rdy0, 4'h8);
    chk("bp release sel", out_sel0, 2'd3);
    chk("bp release data", out_data0, 4'h7);

    // reset asserted mid-stream, away from any clock edge
    step(4'hF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {out_valid1, out_valid0}, 2'b00);
    chk("midrst out_data", out_data0, 4'h0);
    chk("midrst out_sel", out_sel0, 2'd0);
    chk("midrst in_ready", {in_ready1, in_ready0}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(4'h6, 1'b1);
    chk("post-rst first grant", out_sel0, 2'd1);
    step(4'h9, 1'b1);
    chk("post-rst ptr advanced", out_sel0, 2'd3);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_data = 16'($urandom);
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
